// File: rtl/nios2_c_cpu_oci_dct_packer.sv
// Packs 2-bit direct-branch trace atoms into a 30-bit word (15 atoms) plus a 4-bit count.
// Latency: atom to dct_count/dct_buffer is 1 edge; the 15th atom reaches pkt_valid 1 edge later if the output register is free.
// Backpressure: never stalls the producer; while a full word waits on pkt_ready, further atoms are dropped and counted.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   atom_valid, atom_code[1:0]   incoming atom (code 00 is idle and ignored)
//   flush                        close the current partial word
//   pkt_valid/pkt_ready/pkt_data one-entry valid/ready output {count, buffer}
//   dct_buffer, dct_count        live accumulator contents
//   overflow, drop_count         sticky drop flag and saturating drop counter
module nios2_c_cpu_oci_dct_packer #(
    parameter int ATOM_W = 2,
    parameter int ATOMS  = 15,
    parameter int BUF_W  = ATOM_W * ATOMS,
    parameter int CNT_W  = 4,
    parameter int DROP_W = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    atom_valid,
    input  logic [ATOM_W-1:0]       atom_code,
    input  logic                    flush,
    input  logic                    pkt_ready,
    output logic                    pkt_valid,
    output logic [CNT_W+BUF_W-1:0]  pkt_data,
    output logic [BUF_W-1:0]        dct_buffer,
    output logic [CNT_W-1:0]        dct_count,
    output logic                    overflow,
    output logic [DROP_W-1:0]       drop_count
);

    typedef enum logic {ACCUM, CLOSE_PEND} state_t;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ATOMS);

    state_t                   state_q, state_d;
    logic [BUF_W-1:0]         buf_q, buf_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     pv_q, pv_d;
    logic [CNT_W+BUF_W-1:0]   pdat_q, pdat_d;
    logic                     fpend_q, fpend_d;
    logic                     ovf_q, ovf_d;
    logic [DROP_W-1:0]        drop_q, drop_d;

    logic                     accept;
    logic                     out_free;
    logic                     full;
    logic                     flush_req;
    logic                     trigger;
    logic [BUF_W-1:0]         post_buf;
    logic [CNT_W-1:0]         post_cnt;

    assign accept    = atom_valid && (atom_code != '0);
    assign out_free  = !pv_q || pkt_ready;
    assign full      = (cnt_q == CNT_FULL);
    assign flush_req = flush || fpend_q;

    // Accumulator contents after taking this cycle's atom (only when not full).
    always_comb begin
        post_buf = buf_q;
        post_cnt = cnt_q;
        if (accept && !full) begin
            post_buf = {buf_q[BUF_W-ATOM_W-1:0], atom_code};
            post_cnt = cnt_q + 1'b1;
        end
    end

    assign trigger = (post_cnt == CNT_FULL) || (flush_req && (post_cnt != '0));

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        pv_d    = pv_q && !pkt_ready;
        pdat_d  = pdat_q;
        fpend_d = fpend_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;

        if (accept && full) begin
            if (out_free) begin
                // The held full word closes now; the new atom starts the next word.
                pv_d    = 1'b1;
                pdat_d  = {cnt_q, buf_q};
                buf_d   = {{(BUF_W-ATOM_W){1'b0}}, atom_code};
                cnt_d   = CNT_W'(1);
                fpend_d = flush;
                // A fresh flush must close the new one-atom word, but the
                // output register just became busy again.
                state_d = flush ? CLOSE_PEND : ACCUM;
            end else begin
                ovf_d  = 1'b1;
                drop_d = (drop_q == '1) ? drop_q : drop_q + 1'b1;
            end
        end else if (trigger) begin
            if (out_free) begin
                pv_d    = 1'b1;
                pdat_d  = {post_cnt, post_buf};
                buf_d   = '0;
                cnt_d   = '0;
                fpend_d = 1'b0;
                state_d = ACCUM;
            end else begin
                buf_d   = post_buf;
                cnt_d   = post_cnt;
                fpend_d = flush_req;
                state_d = CLOSE_PEND;
            end
        end else begin
            buf_d = post_buf;
            cnt_d = post_cnt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ACCUM;
            buf_q   <= '0;
            cnt_q   <= '0;
            pv_q    <= 1'b0;
            pdat_q  <= '0;
            fpend_q <= 1'b0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            pv_q    <= pv_d;
            pdat_q  <= pdat_d;
            fpend_q <= fpend_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    assign pkt_valid  = pv_q;
    assign pkt_data   = pdat_q;
    assign dct_buffer = buf_q;
    assign dct_count  = cnt_q;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_nios2_c_cpu_oci_dct_packer.sv
// Directed bench for the trace atom packer with hand-computed expected values.
// Latency: inputs are driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: pkt_ready is driven directly to exercise hold, pending close and drop.
module tb_nios2_c_cpu_oci_dct_packer;

    logic        clk;
    logic        reset_n;
    logic        atom_valid;
    logic [1:0]  atom_code;
    logic        flush;
    logic        pkt_ready;
    logic        pkt_valid;
    logic [33:0] pkt_data;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        overflow;
    logic [7:0]  drop_count;

    int n_checks = 0;
    int n_fails  = 0;
    logic [29:0] exp_buf;

    nios2_c_cpu_oci_dct_packer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .atom_valid (atom_valid),
        .atom_code  (atom_code),
        .flush      (flush),
        .pkt_ready  (pkt_ready),
        .pkt_valid  (pkt_valid),
        .pkt_data   (pkt_data),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n    = 1'b0;
        atom_valid = 1'b0;
        atom_code  = 2'b00;
        flush      = 1'b0;
        pkt_ready  = 1'b1;
        #3;
        check("rst_pkt_valid",  64'(pkt_valid),  64'd0);
        check("rst_pkt_data",   64'(pkt_data),   64'd0);
        check("rst_dct_buffer", 64'(dct_buffer), 64'd0);
        check("rst_dct_count",  64'(dct_count),  64'd0);
        check("rst_overflow",   64'(overflow),   64'd0);
        check("rst_drop_count", 64'(drop_count), 64'd0);
        step();
        reset_n = 1'b1;
        step();

        // 15 taken atoms, output free
        exp_buf = '0;
        for (int i = 1; i <= 15; i++) begin
            atom_valid = 1'b1;
            atom_code  = 2'b10;
            step();
            exp_buf = {exp_buf[27:0], 2'b10};
            if (i < 15) begin
                check("fill_count", 64'(dct_count), 64'(i));
                check("fill_buf", 64'(dct_buffer), 64'(exp_buf));
                check("fill_no_pkt", 64'(pkt_valid), 64'd0);
            end
        end
        check("w1_valid", 64'(pkt_valid), 64'd1);
        check("w1_data", 64'(pkt_data), 64'({4'hF, 30'h2AAAAAAA}));
        check("w1_acc_cleared", 64'(dct_count), 64'd0);
        atom_valid = 1'b0;
        step();
        check("w1_drained", 64'(pkt_valid), 64'd0);

        // 01,10,11 then flush
        atom_valid = 1'b1; atom_code = 2'b01; step();
        atom_code = 2'b10; step();
        atom_code = 2'b11; step();
        check("pre_flush_buf", 64'(dct_buffer), 64'h1B);
        atom_valid = 1'b0; flush = 1'b1; step();
        check("flush_valid", 64'(pkt_valid), 64'd1);
        check("flush_data", 64'(pkt_data), 64'({4'h3, 30'h0000001B}));
        check("flush_cnt_clr", 64'(dct_count), 64'd0);
        check("flush_buf_clr", 64'(dct_buffer), 64'd0);
        step();
        check("empty_flush_no_pkt", 64'(pkt_valid), 64'd0);
        flush = 1'b0;

        // idle code 00 ignored
        atom_valid = 1'b1; atom_code = 2'b00;
        for (int i = 0; i < 5; i++) step();
        check("idle_count", 64'(dct_count), 64'd0);
        check("idle_no_pkt", 64'(pkt_valid), 64'd0);
        check("idle_no_drop", 64'(drop_count), 64'd0);

        // backpressure: 30 atoms 01, then 3 dropped
        pkt_ready = 1'b0;
        atom_code = 2'b01;
        for (int i = 0; i < 15; i++) step();
        check("bp_w1_valid", 64'(pkt_valid), 64'd1);
        check("bp_w1_data", 64'(pkt_data), 64'({4'hF, 30'h15555555}));
        check("bp_w1_cnt", 64'(dct_count), 64'd0);
        for (int i = 0; i < 15; i++) step();
        check("bp_w1_held", 64'(pkt_data), 64'({4'hF, 30'h15555555}));
        check("bp_w2_cnt", 64'(dct_count), 64'd15);
        check("bp_w2_buf", 64'(dct_buffer), 64'h15555555);
        check("bp_no_ovf_yet", 64'(overflow), 64'd0);
        for (int i = 0; i < 3; i++) step();
        check("drop_count3", 64'(drop_count), 64'd3);
        check("drop_ovf", 64'(overflow), 64'd1);
        check("drop_acc_kept", 64'(dct_count), 64'd15);
        atom_valid = 1'b0; pkt_ready = 1'b1; step();
        check("w2_valid", 64'(pkt_valid), 64'd1);
        check("w2_data", 64'(pkt_data), 64'({4'hF, 30'h15555555}));
        check("w2_acc_clr", 64'(dct_count), 64'd0);
        step();
        check("w2_drained", 64'(pkt_valid), 64'd0);

        // atom + flush on the same edge
        atom_valid = 1'b1; atom_code = 2'b01; step(); step();
        check("af_pre_buf", 64'(dct_buffer), 64'h5);
        atom_code = 2'b10; flush = 1'b1; step();
        check("af_valid", 64'(pkt_valid), 64'd1);
        check("af_data", 64'(pkt_data), 64'({4'h3, 30'h00000016}));

        // flush while output busy: latched, later atom joins the pending word
        pkt_ready = 1'b0; atom_code = 2'b01; flush = 1'b1; step();
        check("fp_cnt1", 64'(dct_count), 64'd1);
        check("fp_held", 64'(pkt_data), 64'({4'h3, 30'h00000016}));
        flush = 1'b0; atom_code = 2'b10; step();
        check("fp_cnt2", 64'(dct_count), 64'd2);
        check("fp_buf", 64'(dct_buffer), 64'h6);
        atom_valid = 1'b0; pkt_ready = 1'b1; step();
        check("fp_data", 64'(pkt_data), 64'({4'h2, 30'h00000006}));
        check("fp_acc_clr", 64'(dct_count), 64'd0);

        // reset mid-word with a packet held
        pkt_ready = 1'b0; atom_valid = 1'b1; atom_code = 2'b11;
        for (int i = 0; i < 7; i++) step();
        check("mid_cnt7", 64'(dct_count), 64'd7);
        check("mid_buf", 64'(dct_buffer), 64'h3FFF);
        check("mid_pkt_held", 64'(pkt_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mr_pkt_valid", 64'(pkt_valid), 64'd0);
        check("mr_pkt_data", 64'(pkt_data), 64'd0);
        check("mr_count", 64'(dct_count), 64'd0);
        check("mr_buf", 64'(dct_buffer), 64'd0);
        check("mr_overflow", 64'(overflow), 64'd0);
        check("mr_drop", 64'(drop_count), 64'd0);
        atom_valid = 1'b0;
        step();
        reset_n = 1'b1;
        atom_valid = 1'b1; atom_code = 2'b10; step();
        check("post_rst_cnt", 64'(dct_count), 64'd1);
        check("post_rst_buf", 64'(dct_buffer), 64'h2);
        atom_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/nios2_c_cpu_oci_dct_packer.md
Name: nios2_c_cpu_oci_dct_packer

Overview:
Packs 2-bit direct-branch trace atoms from the Nios II OCI trace path into a 30-bit compressed trace word (15 atoms) with a 4-bit atom count. The live accumulator drives dct_buffer/dct_count straight into the OCI test bench monitor. Completed words go out through a one-entry valid/ready packet register to the trace FIFO. Trace must never stall the CPU: when the output cannot drain, atoms are dropped and the loss is flagged.

Parameters:
ATOM_W, 2, bits per trace atom
ATOMS, 15, atoms per compressed word
BUF_W, 30, buffer width (ATOM_W*ATOMS)
CNT_W, 4, count width
DROP_W, 8, saturating dropped-atom counter width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
atom_valid  in  1  atom_code valid this cycle
atom_code  in  2  01 not-taken, 10 taken, 11 exception marker, 00 idle
flush  in  1  close the current word (e.g. trace stop/test_ending)
pkt_ready  in  1  downstream FIFO accepts pkt
pkt_valid  out  1  pkt_data holds a closed word
pkt_data  out  34  {count[3:0], buffer[29:0]}
dct_buffer  out  30  live accumulator contents
dct_count  out  4  live atom count in accumulator (0..15)
overflow  out  1  sticky: at least one atom dropped since reset
drop_count  out  8  saturating count of dropped atoms

Behaviour:
- Reset (async, reset_n=0): dct_buffer=0, dct_count=0, pkt_valid=0, pkt_data=0, overflow=0, drop_count=0. Reset mid-word discards the partial word and any held packet.
- Accept: atom_valid=1 and atom_code!=00. atom_code=00 is ignored (no count, no drop).
- Shift rule: buffer <= {buffer[27:0], atom_code}; count <= count+1. Oldest atom is in the MSBs. Unfilled high bits stay 0.
- Output register free: pkt_valid=0, or pkt_valid=1 and pkt_ready=1 in the same cycle.
- Close trigger: either of
  - post-accept count == 15, or
  - flush=1 with post-accept count != 0.
- Close when out reg free: pkt_data <= {post count, post buffer}; pkt_valid <= 1. Accumulator clears to 0/0 on the same edge, so dct_count never shows 15.
- Close when out reg busy: accumulator keeps its contents (count may sit at 15). The pending close is retried every cycle and completes on the first edge where the out reg is free. A flush request latches as flush_pend until that close completes.
- Drop: an accepted atom arriving while count==15 and the out reg is not free is dropped. Effects: overflow <= 1, drop_count += 1 (saturates at 255). Accumulator unchanged.
- Atoms arriving while a flush close is pending but count<15 are accepted and included in the pending word.
- Simultaneous atom + flush: the atom is included first, then the word closes.
- Flush with count==0 and no accepted atom: no packet.
- Pkt handshake: pkt_data must not change while pkt_valid=1 and pkt_ready=0. On pkt_valid & pkt_ready with no new close, pkt_valid <= 0. Back-to-back close + drain in one cycle is allowed.
- Control: two states.
  - ACCUM → CLOSE_PEND when a close trigger occurs and the out reg is busy.
  - CLOSE_PEND → ACCUM when the close completes.
- Latency: atom to dct_count/dct_buffer update is 1 edge. 15th atom to pkt_valid is 1 edge when the out reg is free.

Test Plan:
- Reset, then 15 atoms 10 every cycle with pkt_ready=1 → after the 15th edge pkt_valid=1, pkt_data={4'hF,30'h2AAAAAAA}, dct_count=0. During the fill dct_count steps 1..14.
- Atoms 01,10,11 then flush with pkt_ready=1 → pkt_data={4'h3,30'h0000001B}, accumulator cleared. Flush again with nothing pending → no packet.
- pkt_ready=0, send 30 atoms 01 then 3 more → first word held unchanged; second word sits at dct_count=15; 3 extra atoms dropped, overflow=1, drop_count=3. Raise pkt_ready → second word {4'hF,30'h15555555} presented next.
- atom_valid=1 with atom_code=00 for 5 cycles → dct_count stays 0, no drop, no packet.
- Atom 10 + flush on the same edge at count=2 (buffer 0x5) → pkt_data={4'h3,30'h00000016}.
- Assert reset_n=0 mid-word (count=7) and with pkt_valid=1 → all outputs 0 immediately; overflow and drop_count cleared.
